// File: rtl/bus_sync_ctrl_pkg.sv
// Shared types and constants for the toggle-handshake bus synchronizer.
package bus_sync_pkg;

    localparam int BUS_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        HOLD    = 2'b10
    } state_t;

endpackage

// File: rtl/bus_sync_ctrl_df_sync.sv
// Two-flop synchronizer for single-bit or otherwise safe-to-cross signals.
module DF_Sync #(
    parameter int DATA_SIZE = 1
) (
    input  logic                 sync_clk,
    input  logic                 sync_rstn,
    input  logic [DATA_SIZE-1:0] unsync_bus,
    output logic [DATA_SIZE-1:0] sync_bus
);

    logic [DATA_SIZE-1:0] stage1;

    // Two back-to-back flops give the first stage a full cycle to resolve metastability.
    always_ff @(posedge sync_clk or negedge sync_rstn) begin
        if (!sync_rstn) begin
            stage1   <= '0;
            sync_bus <= '0;
        end else begin
            stage1   <= unsync_bus;
            sync_bus <= stage1;
        end
    end

endmodule

// File: rtl/bus_sync_ctrl.sv
// Receive side of a toggle req/ack bus crossing: detects the request toggle,
// captures the stable source bus, offers it downstream via valid/ready and
// returns an ack toggle to the source.
module bus_sync_ctrl
    import bus_sync_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEFAULT
) (
    input  logic                 sync_clk,
    input  logic                 sync_rstn,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 unsync_req,
    input  logic                 sync_ready,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 sync_valid,
    output logic                 sync_ack,
    output logic                 busy,
    output logic                 proto_err
);

    state_t state;
    state_t state_next;
    logic   req_s;
    logic   req_d;
    logic   req_edge;
    logic   capture_en;
    logic   complete_en;
    logic   lost_req;

    DF_Sync #(
        .DATA_SIZE (1)
    ) u_req_sync (
        .sync_clk   (sync_clk),
        .sync_rstn  (sync_rstn),
        .unsync_bus (unsync_req),
        .sync_bus   (req_s)
    );

    assign req_edge = req_s ^ req_d;
    assign lost_req = req_edge && (state != IDLE);

    // Delayed copy of the synchronized request, used only for toggle detection.
    always_ff @(posedge sync_clk or negedge sync_rstn) begin
        if (!sync_rstn) begin
            req_d <= 1'b0;
        end else begin
            req_d <= req_s;
        end
    end

    // State register.
    always_ff @(posedge sync_clk or negedge sync_rstn) begin
        if (!sync_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus one-cycle strobes for capture and completion.
    always_comb begin
        state_next  = state;
        capture_en  = 1'b0;
        complete_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_edge) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                capture_en = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (sync_valid && sync_ready) begin
                    complete_en = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Captured data persists between transfers; only reset clears it.
    always_ff @(posedge sync_clk or negedge sync_rstn) begin
        if (!sync_rstn) begin
            sync_bus <= '0;
        end else if (capture_en) begin
            sync_bus <= unsync_bus;
        end
    end

    // Valid rises on capture and drops on the accepting handshake; ack toggles at the same moment.
    always_ff @(posedge sync_clk or negedge sync_rstn) begin
        if (!sync_rstn) begin
            sync_valid <= 1'b0;
            sync_ack   <= 1'b0;
        end else if (capture_en) begin
            sync_valid <= 1'b1;
        end else if (complete_en) begin
            sync_valid <= 1'b0;
            sync_ack   <= ~sync_ack;
        end
    end

    // Busy is its own flop tracking state != IDLE so it never glitches on state-bit changes.
    always_ff @(posedge sync_clk or negedge sync_rstn) begin
        if (!sync_rstn) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
        end
    end

    // Sticky flag for a request toggle that arrived while a transfer was in progress.
    always_ff @(posedge sync_clk or negedge sync_rstn) begin
        if (!sync_rstn) begin
            proto_err <= 1'b0;
        end else if (lost_req) begin
            proto_err <= 1'b1;
        end
    end

endmodule
